// File: rtl/dfi_rd_return.sv
// dfi_rd_return: read-return stage behind the DFI read port.
//
// Schedules dfi_rddata_en cfg_trddata_en cycles after each accepted RD command. Captures DFI
// read beats, tags them with the command ID and buffers them in a beat FIFO. The FIFO drains
// to the scheduler over a valid/ready channel. RD credit reserves beat FIFO space at issue
// time, so captured data always has room.
//
// Optional feature (compile-time macro DFI_RD_DNV_EN):
//   defined   - captured beat err = |dfi_rddata_dnv, carried through the FIFO to r_err
//   undefined - dfi_rddata_dnv ignored, r_err tied to 0, no err bit stored
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_trddata_en      RD issue -> first dfi_rddata_en delay in cycles (>= 1, quasi-static)
//   rd_issue, rd_id     RD command strobe and its ID
//   rd_credit           registered: one more RD may be issued next cycle
//   dfi_rddata_en       DFI read enable
//   dfi_rddata*         DFI read data, valid and per-byte data-not-valid
//   r_valid/r_ready     response beat handshake; r_id, r_data, r_last, r_err carry the beat
//   err_sticky          protocol violation seen (overlap, spurious data, issue w/o credit)
module dfi_rd_return #(
  parameter int unsigned BURST_BEATS     = 2,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DATA_DEPTH      = 16,
  parameter int unsigned TRD_WIDTH       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TRD_WIDTH-1:0] cfg_trddata_en,
  input  logic                 rd_issue,
  input  logic [ID_WIDTH-1:0]  rd_id,
  output logic                 rd_credit,
  output logic                 dfi_rddata_en,
  input  logic [127:0]         dfi_rddata,
  input  logic                 dfi_rddata_valid,
  input  logic [15:0]          dfi_rddata_dnv,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [ID_WIDTH-1:0]  r_id,
  output logic [127:0]         r_data,
  output logic                 r_last,
  output logic                 r_err,
  output logic                 err_sticky
);

  localparam int unsigned EnW = 2**TRD_WIDTH + BURST_BEATS;
  localparam int unsigned BcW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int unsigned TpW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned TcW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DpW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned DcW = $clog2(DATA_DEPTH + 1);

  localparam logic [EnW-1:0] BurstMask = {{(EnW-BURST_BEATS){1'b0}}, {BURST_BEATS{1'b1}}};

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [127:0]        data;
    logic                last;
`ifdef DFI_RD_DNV_EN
    logic                err;
`endif
  } beat_t;

  // Enable scheduling
  logic [EnW-1:0] en_q, en_d, new_bits;
  logic           issue_ok, overlap;

  // Tag FIFO and beat counter
  logic [ID_WIDTH-1:0] tag_mem [MAX_OUTSTANDING];
  logic [TpW-1:0]      tag_wp_q, tag_rp_q;
  logic [TcW-1:0]      tag_cnt_q, tag_cnt_d;
  logic                tag_push, tag_pop, tag_empty;
  logic [BcW-1:0]      beat_cnt_q, beat_cnt_d;
  logic                beat_last, capture, spurious;

  // Beat FIFO
  beat_t               beat_mem [DATA_DEPTH];
  logic [DpW-1:0]      data_wp_q, data_rp_q;
  logic [DcW-1:0]      data_cnt_q, data_cnt_d;
  logic                beat_push, beat_pop, data_full;
  beat_t               wr_beat, head;

  // Credit and error
  logic [31:0]         reserved;
  logic                credit_q, credit_d;
  logic                err_q, err_d;

  assign issue_ok = rd_issue & credit_q;

  // Bits for a new command are placed at d.. before the shift, so bit 0 of the registered
  // vector goes high exactly d cycles after the issue cycle.
  always_comb begin
    new_bits = issue_ok ? (BurstMask << cfg_trddata_en) : '0;
    overlap  = |(en_q & new_bits);
    en_d     = (en_q | new_bits) >> 1;
  end

  assign tag_empty = (tag_cnt_q == '0);
  assign beat_last = (beat_cnt_q == BcW'(BURST_BEATS - 1));
  assign capture   = dfi_rddata_valid & ~tag_empty;
  assign spurious  = dfi_rddata_valid & tag_empty;
  assign tag_push  = issue_ok;
  assign tag_pop   = capture & beat_last;

  always_comb begin
    tag_cnt_d  = tag_cnt_q + TcW'(tag_push) - TcW'(tag_pop);
    beat_cnt_d = beat_cnt_q;
    if (capture) begin
      beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;
    end
  end

  assign data_full = (data_cnt_q == DcW'(DATA_DEPTH));
  assign beat_pop  = r_valid & r_ready;
  // Credit keeps the FIFO from filling; the full guard only protects against misuse.
  assign beat_push = capture & (~data_full | beat_pop);

  always_comb begin
    wr_beat      = '0;
    wr_beat.id   = tag_mem[tag_rp_q];
    wr_beat.data = dfi_rddata;
    wr_beat.last = beat_last;
`ifdef DFI_RD_DNV_EN
    wr_beat.err  = |dfi_rddata_dnv;
`endif
  end

`ifndef DFI_RD_DNV_EN
  logic unused_dnv;
  assign unused_dnv = ^dfi_rddata_dnv;
`endif

  assign data_cnt_d = data_cnt_q + DcW'(beat_push) - DcW'(beat_pop);

  // Credit is computed from next-state counts so an issue this cycle is already reflected
  // in the registered credit of the next cycle.
  always_comb begin
    reserved = 32'(data_cnt_d) + BURST_BEATS * 32'(tag_cnt_d) - 32'(beat_cnt_d);
    credit_d = (reserved + BURST_BEATS <= DATA_DEPTH) && (tag_cnt_d != TcW'(MAX_OUTSTANDING));
    err_d    = err_q | overlap | spurious | (rd_issue & ~credit_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= '0;
      tag_wp_q   <= '0;
      tag_rp_q   <= '0;
      tag_cnt_q  <= '0;
      beat_cnt_q <= '0;
      data_wp_q  <= '0;
      data_rp_q  <= '0;
      data_cnt_q <= '0;
      credit_q   <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      tag_cnt_q  <= tag_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      data_cnt_q <= data_cnt_d;
      credit_q   <= credit_d;
      err_q      <= err_d;
      if (tag_push) begin
        tag_wp_q <= (tag_wp_q == TpW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wp_q + 1'b1;
      end
      if (tag_pop) begin
        tag_rp_q <= (tag_rp_q == TpW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rp_q + 1'b1;
      end
      if (beat_push) begin
        data_wp_q <= (data_wp_q == DpW'(DATA_DEPTH - 1)) ? '0 : data_wp_q + 1'b1;
      end
      if (beat_pop) begin
        data_rp_q <= (data_rp_q == DpW'(DATA_DEPTH - 1)) ? '0 : data_rp_q + 1'b1;
      end
    end
  end

  // Storage arrays need no reset: occupancy counters decide what is valid.
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[tag_wp_q] <= rd_id;
    end
    if (beat_push) begin
      beat_mem[data_wp_q] <= wr_beat;
    end
  end

  assign head          = beat_mem[data_rp_q];
  assign r_valid       = (data_cnt_q != '0);
  // Outputs are gated so they read 0 whenever no beat is presented.
  assign r_id          = r_valid ? head.id   : '0;
  assign r_data        = r_valid ? head.data : '0;
  assign r_last        = r_valid & head.last;
`ifdef DFI_RD_DNV_EN
  assign r_err         = r_valid & head.err;
`else
  assign r_err         = 1'b0;
`endif
  assign rd_credit     = credit_q;
  assign dfi_rddata_en = en_q[0];
  assign err_sticky    = err_q;

endmodule
